seq_rev_shifter: RTL and testbench
==================================

Name: seq_rev_shifter

Overview:
- Multi-cycle iterative shifter for the 16-bit ALU datapath. It covers the opposite-direction counterparts of the existing combinational shift ops: SRL (logical right), SLA (arithmetic left with overflow detect) and ROL (rotate left).
- Shifts 1 bit per clock.
- Uses a valid/ready handshake on both input and output, so the execute stage can stall on it.

Parameters:
- WIDTH, 16, data width of operand and result.
- AMT_W, 4, width of the shift amount (the low AMT_W bits of b are used).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  block idle, can accept a request
- opcode  input  2  00 SRL, 01 SLA, 10 ROL, 11 reserved (pass-through)
- a  input  WIDTH  operand (rs)
- b  input  WIDTH  shift amount; only b[AMT_W-1:0] is used, upper bits are ignored
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  shifted value (rd)
- ovf  output  1  SLA overflow (sticky over all steps); 0 for the other ops
- zero  output  1  result == 0

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state IDLE, result 0, ovf 0, out_valid 0, internal count 0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Outputs in_ready and out_valid are decoded from the state register only. No combinational path from in_valid or out_ready.
- Accept: on an edge with in_valid && in_ready, latch a into the working register, latch opcode, set count = b[AMT_W-1:0], clear ovf, go to SHIFT.
  - Opcode 11: count is forced to 0.
- SHIFT, each edge:
  - If count == 0, go to DONE with no data change.
  - Otherwise apply one step, count-1, stay in SHIFT.
- One step, per opcode:
  - SRL: {1'b0, r[WIDTH-1:1]}
  - SLA: {r[WIDTH-2:0], 1'b0}; ovf |= r[WIDTH-1] ^ r[WIDTH-2]
  - ROL: {r[WIDTH-2:0], r[WIDTH-1]}
  - 11: no step occurs.
- Latency: out_valid rises amt+1 cycles after the accept edge. amt=0 gives 1 cycle; amt=15 gives 16 cycles.
- DONE:
  - result, ovf and zero are held stable while out_valid=1 && !out_ready.
  - On out_valid && out_ready, go to IDLE.
  - There is no same-edge re-accept: a new request is accepted at the earliest one cycle after the handshake.
- in_valid while busy is ignored. The operands are not re-sampled.
- zero = (result == 0), combinational from the result register.
- Reset mid-operation (SHIFT or DONE): the operation is abandoned, state returns to IDLE on that edge, all outputs take their reset values, and no out_valid pulse is produced.
- rst and in_valid on the same edge: reset wins and the request is dropped.
- Width rules: a shift of 0 returns a unchanged. A ROL by WIDTH is not representable with AMT_W=4.

Decomposition:
- Package shift_pkg:
  - typedef enum logic [1:0] shop_t {SH_SRL, SH_SLA, SH_ROL, SH_PASS}
  - typedef enum logic [1:0] shst_t {ST_IDLE, ST_SHIFT, ST_DONE}
  - localparams WIDTH=16, AMT_W=4
- One natural combinational sub-module, shift_step: inputs op and r, outputs next r and step_ovf. It keeps the per-op datapath separate from the FSM and counter.

Test Plan:
- SRL: a=0x8001, b=4, out_ready=1 -> result 0x0800, ovf 0, zero 0, out_valid 5 cycles after accept.
- ROL: a=0x0001, b=15 -> result 0x8000 after 16 cycles. Then ROL a=0x8001, b=4 -> 0x0018.
- SLA overflow:
  - a=0x4000, b=1 -> result 0x8000, ovf 1.
  - a=0xC000, b=1 -> result 0x8000, ovf 0.
  - a=0x0003, b=2 -> result 0x000C, ovf 0.
- Zero shift, pass-through and ignored upper bits:
  - SRL a=0x1234, b=0 -> result 0x1234 in 1 cycle.
  - opcode 11, a=0xBEEF, b=7 -> result 0xBEEF in 1 cycle.
  - SRL a=0x0001, b=0xFFF1 -> result 0x0000, zero 1.
- Backpressure and busy:
  - Hold out_ready=0 for 10 cycles in DONE -> result and out_valid stable.
  - in_valid pulses while busy -> ignored.
  - After the handshake, in_ready=1 on the next cycle.
- Reset: assert rst during SHIFT (ROL a=0x00FF, b=8, third cycle) -> next cycle IDLE, result 0, out_valid never asserted. A subsequent request completes normally.

Source files
------------

// File: rtl/seq_rev_shifter_pkg.sv
// Shared types and sizing for the iterative reverse-direction shifter.
package shift_pkg;
    localparam int WIDTH = 16;
    localparam int AMT_W = 4;

    typedef enum logic [1:0] {SH_SRL, SH_SLA, SH_ROL, SH_PASS} shop_t;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} shst_t;
endpackage

// File: rtl/seq_rev_shifter_step.sv
// One-bit shift step for SRL / SLA / ROL; the reserved opcode leaves the value untouched.
module shift_step #(
    parameter int WIDTH = shift_pkg::WIDTH
) (
    input  shift_pkg::shop_t   i_op,
    input  logic [WIDTH-1:0]   i_r,
    output logic [WIDTH-1:0]   o_r,
    output logic               o_step_ovf
);
    import shift_pkg::*;

    always_comb begin
        o_r        = i_r;
        o_step_ovf = 1'b0;
        case (i_op)
            SH_SRL: o_r = {1'b0, i_r[WIDTH-1:1]};
            SH_SLA: begin
                o_r        = {i_r[WIDTH-2:0], 1'b0};
                // Sign changes whenever the two top bits differ before the step.
                o_step_ovf = i_r[WIDTH-1] ^ i_r[WIDTH-2];
            end
            SH_ROL: o_r = {i_r[WIDTH-2:0], i_r[WIDTH-1]};
            default: ;
        endcase
    end
endmodule

// File: rtl/seq_rev_shifter.sv
// Iterative 1-bit-per-clock shifter (SRL/SLA/ROL) with valid/ready on both sides.
// Handshake: a transfer happens on an edge where valid && ready; in_ready and out_valid depend on state only.
module seq_rev_shifter #(
    parameter int WIDTH = shift_pkg::WIDTH,
    parameter int AMT_W = shift_pkg::AMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             zero,
    output logic [1:0]       dbg_state
);
    import shift_pkg::*;

    shst_t             r_state;
    shst_t             w_state_next;
    shop_t             r_op;
    logic [WIDTH-1:0]  r_data;
    logic [AMT_W-1:0]  r_count;
    logic              r_ovf;
    logic [WIDTH-1:0]  w_step_data;
    logic              w_step_ovf;
    logic              w_count_zero;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .i_op       (r_op),
        .i_r        (r_data),
        .o_r        (w_step_data),
        .o_step_ovf (w_step_ovf)
    );

    assign w_count_zero = (r_count == '0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_count_zero) w_state_next = ST_DONE;
            ST_DONE:  if (out_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= SH_SRL;
            r_data  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: if (in_valid) begin
                    r_data  <= a;
                    r_op    <= shop_t'(opcode);
                    // Reserved opcode completes immediately as a pass-through.
                    r_count <= (shop_t'(opcode) == SH_PASS) ? '0 : b[AMT_W-1:0];
                    r_ovf   <= 1'b0;
                end
                ST_SHIFT: if (!w_count_zero) begin
                    r_data  <= w_step_data;
                    r_ovf   <= r_ovf | w_step_ovf;
                    r_count <= r_count - {{(AMT_W-1){1'b0}}, 1'b1};
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_data;
    assign ovf       = r_ovf;
    assign zero      = (r_data == '0);
    assign dbg_state = r_state;
endmodule

// File: tb/tb_seq_rev_shifter.sv
// Bench for seq_rev_shifter: directed vector table, random ops against a reference model, corner sequences.
module tb_seq_rev_shifter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  opcode = 2'd0;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        ovf;
    logic        zero;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    seq_rev_shifter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf), .zero(zero), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] av;
        logic [15:0] bv;
        logic [15:0] exp_r;
        logic        exp_o;
        logic        exp_z;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: whole-shift arithmetic on the operand, no per-step iteration.
    function automatic void model(input logic [1:0] op, input logic [15:0] av, input logic [15:0] bv,
                                  output logic [15:0] r, output logic o, output int lat);
        int amt;
        logic [31:0] x;
        logic [31:0] top;
        amt = (op == 2'd3) ? 0 : int'(bv[3:0]);
        x   = {16'h0, av};
        o   = 1'b0;
        r   = av;
        lat = amt + 1;
        case (op)
            2'd0: r = av >> amt;
            2'd1: begin
                r   = 16'(x << amt);
                top = x >> (15 - amt);
                o   = !(top == 0 || top == ((32'd1 << (amt + 1)) - 1));
            end
            2'd2: r = 16'((x << amt) | (x >> (16 - amt)));
            default: r = av;
        endcase
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [15:0] av, input logic [15:0] bv);
        int n = 0;
        while (!in_ready && n < 60) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("start_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        opcode = op; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid && lat < 40);
        if (!out_valid) chk("done_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        start_op(v.op, v.av, v.bv);
        wait_done(lat);
        chk({nm, "_result"}, 32'(result), 32'(v.exp_r));
        chk({nm, "_ovf"}, 32'(ovf), 32'(v.exp_o));
        chk({nm, "_zero"}, 32'(zero), 32'(v.exp_z));
        chk({nm, "_lat"}, 32'(lat), 32'(v.exp_lat));
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        logic [15:0] er, held_r, ra, rb;
        logic        eo, held_o;
        logic [1:0]  rop;
        int          el;
        int          seen;

        vecs[0] = '{2'd0, 16'h8001, 16'd4,    16'h0800, 1'b0, 1'b0, 5};
        vecs[1] = '{2'd2, 16'h0001, 16'd15,   16'h8000, 1'b0, 1'b0, 16};
        vecs[2] = '{2'd2, 16'h8001, 16'd4,    16'h0018, 1'b0, 1'b0, 5};
        vecs[3] = '{2'd1, 16'h4000, 16'd1,    16'h8000, 1'b1, 1'b0, 2};
        vecs[4] = '{2'd1, 16'hC000, 16'd1,    16'h8000, 1'b0, 1'b0, 2};
        vecs[5] = '{2'd1, 16'h0003, 16'd2,    16'h000C, 1'b0, 1'b0, 3};
        vecs[6] = '{2'd0, 16'h1234, 16'd0,    16'h1234, 1'b0, 1'b0, 1};
        vecs[7] = '{2'd3, 16'hBEEF, 16'd7,    16'hBEEF, 1'b0, 1'b0, 1};
        vecs[8] = '{2'd0, 16'h0001, 16'hFFF1, 16'h0000, 1'b0, 1'b1, 2};
        vecs[9] = '{2'd1, 16'h0001, 16'd15,   16'h8000, 1'b1, 1'b0, 16};

        // Clock/reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure in DONE plus busy in_valid pulses.
        out_ready = 1'b0;
        start_op(2'd1, 16'h0F0F, 16'd6);
        model(2'd1, 16'h0F0F, 16'd6, er, eo, el);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); in_valid = 1'b1; a = 16'hFFFF; b = 16'd1; opcode = 2'd0;
        end
        @(negedge clk); in_valid = 1'b0;
        wait_done(lat);
        chk("bp_result", 32'(result), 32'(er));
        chk("bp_ovf", 32'(ovf), 32'(eo));
        held_r = result; held_o = ovf;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); in_valid = (k % 2 == 0);
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || result !== held_r || ovf !== held_o || in_ready !== 1'b0) seen++;
        end
        in_valid = 1'b0;
        chk("bp_stable_cycles_bad", 32'(seen), 32'd0);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_in_ready", 32'(in_ready), 32'd1);
        chk("hs_out_valid", 32'(out_valid), 32'd0);

        // Reset during SHIFT abandons the op.
        start_op(2'd2, 16'h00FF, 16'd8);
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_state", 32'(dbg_state), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("mid_rst_no_valid", 32'(seen), 32'd0);
        run_vec('{2'd2, 16'h00FF, 16'd8, 16'hFF00, 1'b0, 1'b0, 9}, "after_rst");

        // Reset and in_valid on the same edge: request dropped.
        @(negedge clk); rst = 1'b1; in_valid = 1'b1; a = 16'h1111; b = 16'd2; opcode = 2'd0;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen++;
        end
        chk("rst_wins_idle", 32'(seen), 32'd0);

        // Random ops against the model, random consumer delay.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            model(rop, ra, rb, er, eo, el);
            exp_q.push_back(er);
            out_ready = ($urandom_range(0, 2) != 0);
            start_op(rop, ra, rb);
            wait_done(lat);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            chk($sformatf("rnd%0d_result", i), 32'(result), 32'(exp_q.pop_front()));
            chk($sformatf("rnd%0d_ovf", i), 32'(ovf), 32'(eo));
            chk($sformatf("rnd%0d_zero", i), 32'(zero), 32'(er == 16'h0));
            if (out_ready) chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(el));
            @(negedge clk); out_ready = 1'b1;
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
